// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the 64-bit LFSR stream (taps 63,62,60,59).
// Optional seed load port pair is enabled by defining LFSR_CHK_SEED_EN.
module lfsr_stream_checker #(
  parameter int LOCK_MATCHES = 64,
  parameter int LOSS_WINDOW  = 128,
  parameter int LOSS_THRESH  = 8,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear_counts,
`ifdef LFSR_CHK_SEED_EN
  input  logic [63:0]          seed,
  input  logic                 seed_load,
`endif
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          bit_count
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(LOSS_WINDOW - 1);
  localparam logic [EW-1:0] THR_LAST   = EW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t                 r_state;
  logic [63:0]            r_sr;
  logic [5:0]             r_fill;
  logic [MW-1:0]          r_match;
  logic [WW-1:0]          r_win_cnt;
  logic [EW-1:0]          r_win_err;
  logic                   r_locked;
  logic                   r_err_pulse;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [31:0]            r_bit_cnt;

  logic                   w_pred;
  logic                   w_err;
  logic                   w_seed;
  logic [63:0]            w_seed_val;
  logic                   w_beat_lk;

`ifdef LFSR_CHK_SEED_EN
  assign w_seed     = seed_load && (seed != 64'd0);
  assign w_seed_val = seed;
`else
  assign w_seed     = 1'b0;
  assign w_seed_val = 64'd0;
`endif

  assign w_pred    = r_sr[63] ^ r_sr[62] ^ r_sr[60] ^ r_sr[59];
  assign w_err     = in_bit ^ w_pred;
  assign w_beat_lk = !w_seed && in_valid && (r_state == S_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HUNT;
      r_sr        <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_seed) begin
        r_sr      <= w_seed_val;
        r_state   <= S_LOCKED;
        r_locked  <= 1'b1;
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else if (in_valid) begin
        unique case (r_state)
          S_HUNT: begin
            r_sr   <= {r_sr[62:0], in_bit};
            r_fill <= r_fill + 6'd1;
            if (r_fill == 6'd63) begin
              r_state <= S_VERIFY;
              r_match <= '0;
            end
          end
          S_VERIFY: begin
            r_sr <= {r_sr[62:0], in_bit};
            // an all-zero shadow trivially predicts zeros, so it never counts
            if (!w_err && (r_sr != 64'd0)) begin
              if (r_match == MATCH_LAST) begin
                r_state   <= S_LOCKED;
                r_locked  <= 1'b1;
                r_match   <= '0;
                r_win_cnt <= '0;
                r_win_err <= '0;
              end else begin
                r_match <= r_match + MW'(1);
              end
            end else begin
              r_match <= '0;
            end
          end
          S_LOCKED: begin
            r_sr        <= {r_sr[62:0], w_pred};
            r_err_pulse <= w_err;
            if (w_err && (r_win_err == THR_LAST)) begin
              r_state   <= S_HUNT;
              r_locked  <= 1'b0;
              r_fill    <= '0;
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else if (r_win_cnt == WIN_LAST) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WW'(1);
              r_win_err <= r_win_err + EW'(w_err);
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
      if (clear_counts) begin
        r_bit_cnt <= '0;
        r_err_cnt <= '0;
      end else if (w_beat_lk) begin
        if (r_bit_cnt != '1)
          r_bit_cnt <= r_bit_cnt + 32'd1;
        if (w_err && (r_err_cnt != '1))
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_cnt;
  assign bit_count = r_bit_cnt;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Randomised bench for lfsr_stream_checker against a queue-based
// behavioural model of hunt/verify/lock and windowed loss of lock.
module tb_lfsr_stream_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_bit;
  logic        clear_counts;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;
`ifdef LFSR_CHK_SEED_EN
  logic [63:0] seed;
  logic        seed_load;
`endif

  int n_chk;
  int n_err;

  lfsr_stream_checker dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .clear_counts (clear_counts),
`ifdef LFSR_CHK_SEED_EN
    .seed         (seed),
    .seed_load    (seed_load),
`endif
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .bit_count    (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // generator side
  logic [63:0] g;

  function automatic logic gen_next();
    logic fb;
    fb = g[63] ^ g[62] ^ g[60] ^ g[59];
    g  = {g[62:0], fb};
    return fb;
  endfunction

  // reference model: sh[k] is the bit received k beats ago
  bit    sh[$];
  int    m_mode;
  int    m_fill;
  int    m_match;
  int    m_wcnt;
  int    m_werr;
  longint m_bits;
  longint m_errs;
  bit    m_pulse;

  function automatic bit m_pred();
    return sh[63] ^ sh[62] ^ sh[60] ^ sh[59];
  endfunction

  function automatic bit m_nonzero();
    foreach (sh[k]) if (sh[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_push(bit b);
    sh.push_front(b);
    void'(sh.pop_back());
  endfunction

  function automatic void model_reset();
    sh.delete();
    for (int k = 0; k < 64; k++) sh.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_match = 0;
    m_wcnt = 0; m_werr = 0;
    m_bits = 0; m_errs = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(bit v, bit b, bit clr);
    bit p;
    bit e;
    bit nz;
    m_pulse = 0;
    if (v) begin
      p = m_pred();
      if (m_mode == 0) begin
        m_push(b);
        m_fill++;
        if (m_fill == 64) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        nz = m_nonzero();
        m_push(b);
        if (b == p && nz) begin
          m_match++;
          if (m_match == 64) begin
            m_mode = 2; m_match = 0; m_wcnt = 0; m_werr = 0;
          end
        end else m_match = 0;
      end else begin
        e = (b != p);
        m_push(p);
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (e) begin
          m_pulse = 1;
          if (m_errs < 65535) m_errs++;
        end
        m_werr += int'(e);
        m_wcnt++;
        if (m_werr == 8) begin
          m_mode = 0; m_fill = 0; m_wcnt = 0; m_werr = 0;
        end else if (m_wcnt == 128) begin
          m_wcnt = 0; m_werr = 0;
        end
      end
    end
    if (clr) begin m_bits = 0; m_errs = 0; end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_locked"}, 64'(locked), 64'(m_mode == 2));
    chk({tag, "_pulse"}, 64'(err_pulse), 64'(m_pulse));
    chk({tag, "_errcnt"}, 64'(err_count), 64'(m_errs));
    chk({tag, "_bitcnt"}, 64'(bit_count), 64'(m_bits));
  endtask

  task automatic cycle(input bit v, input bit b, input bit clr);
    @(negedge clk);
    in_valid = v; in_bit = b; clear_counts = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    chk_all("cyc");
  endtask

  task automatic beat(input bit flip, input bit clr);
    logic b;
    b = gen_next() ^ flip;
    cycle(1'b1, b, clr);
  endtask

  task automatic idle();
    cycle(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk_all("rst");
    @(negedge clk);
    in_valid = 1'b0; in_bit = 1'b0; clear_counts = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int pos [8];
    int k;
    n_chk = 0; n_err = 0;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_counts = 1'b0;
`ifdef LFSR_CHK_SEED_EN
    seed = 64'd0; seed_load = 1'b0;
`endif
    model_reset();

    // contiguous lock
    do_reset();
    g = 64'hACE1_ACE1_ACE1_ACE1;
    for (int i = 1; i <= 300; i++) begin
      beat(1'b0, 1'b0);
      if (i == 127) chk("t1_nolock127", 64'(locked), 64'd0);
      if (i == 128) chk("t1_lock128", 64'(locked), 64'd1);
    end
    chk("t1_bits", 64'(bit_count), 64'd172);
    chk("t1_errs", 64'(err_count), 64'd0);

    // single flipped beat
    do_reset();
    g = 64'hACE1_ACE1_ACE1_ACE1;
    for (int i = 1; i <= 300; i++) begin
      beat(i == 200, 1'b0);
      if (i == 200) chk("t2_pulse", 64'(err_pulse), 64'd1);
      if (i == 201) chk("t2_pulse_off", 64'(err_pulse), 64'd0);
    end
    chk("t2_errs", 64'(err_count), 64'd1);
    chk("t2_locked", 64'(locked), 64'd1);

    // eight errors in one window, then relock
    do_reset();
    g = {$urandom, $urandom} | 64'd1;
    for (int j = 0; j < 8; j++) pos[j] = 140 + j * 13 + int'($urandom_range(5));
    k = 0;
    for (int i = 1; i <= 500; i++) begin
      if (k < 8 && i == pos[k]) begin
        beat(1'b1, 1'b0);
        k++;
        if (k == 8) chk("t3_loss", 64'(locked), 64'd0);
      end else beat(1'b0, 1'b0);
      if (k == 8 && i == pos[7] + 127) chk("t3_pre_relock", 64'(locked), 64'd0);
      if (k == 8 && i == pos[7] + 128) chk("t3_relock", 64'(locked), 64'd1);
    end
    chk("t3_errs", 64'(err_count), 64'd8);

    // all-zero stream
    do_reset();
    for (int i = 0; i < 500; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("t4_locked", 64'(locked), 64'd0);
    chk("t4_errs", 64'(err_count), 64'd0);

    // gapped valid, then reset mid-stream
    do_reset();
    g = 64'hACE1_ACE1_ACE1_ACE1;
    for (int i = 1; i <= 300; i++) begin
      beat(1'b0, 1'b0);
      idle();
    end
    chk("t5_bits", 64'(bit_count), 64'd172);
    chk("t5_locked", 64'(locked), 64'd1);
    do_reset();
    g = {$urandom, $urandom} | 64'd2;
    for (int i = 1; i <= 150; i++) beat(1'b0, 1'b0);
    do_reset();
    for (int i = 1; i <= 200; i++) beat(1'b0, 1'b0);
    chk("t5_relock", 64'(locked), 64'd1);
    chk("t5_bits2", 64'(bit_count), 64'd72);

    // random valid, errors and clears
    do_reset();
    g = {$urandom, $urandom} | 64'd4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) idle();
      else beat(i < 2500 ? ($urandom_range(99) == 0)
                         : ($urandom_range(9) == 0),
                $urandom_range(49) == 0);
    end

`ifdef LFSR_CHK_SEED_EN
    do_reset();
    g = 64'hACE1_ACE1_ACE1_ACE1;
    @(negedge clk);
    seed = g; seed_load = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    sh.delete();
    for (int j = 0; j < 64; j++) sh.push_back(g[j]);
    m_mode = 2; m_wcnt = 0; m_werr = 0; m_pulse = 0;
    #1;
    chk("t6_locked", 64'(locked), 64'd1);
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < 10; i++) beat(1'b0, 1'b0);
    chk("t6_bits", 64'(bit_count), 64'd10);
    chk("t6_errs", 64'(err_count), 64'd0);
    @(negedge clk);
    seed = 64'd0; seed_load = 1'b1;
    @(posedge clk);
    m_pulse = 0;
    #1;
    chk_all("t6_zero");
    @(negedge clk);
    seed_load = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
